// File: rtl/iot_event_serializer_if.sv
// Request/event bus between the IoT device front-end and the event serializer.
// Optional drop_cnt signal exists only when IOT_DROP_COUNT_EN is defined.
interface iot_event_serializer_if #(
    parameter int N_DEV = 8,
    localparam int ID_W = $clog2(N_DEV)
);
    logic [N_DEV-1:0] dev_up;
    logic [N_DEV-1:0] dev_down;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [N_DEV-1:0] active_map;
    logic             busy;
`ifdef IOT_DROP_COUNT_EN
    logic [7:0]       drop_cnt;
`endif

    modport master (
`ifdef IOT_DROP_COUNT_EN
        input  drop_cnt,
`endif
        output dev_up,
        output dev_down,
        input  change,
        input  on_off,
        input  dev_id,
        input  active_map,
        input  busy
    );

    modport slave (
`ifdef IOT_DROP_COUNT_EN
        output drop_cnt,
`endif
        input  dev_up,
        input  dev_down,
        output change,
        output on_off,
        output dev_id,
        output active_map,
        output busy
    );
endinterface

// File: rtl/iot_event_serializer.sv
// Tracks per-device active state and serialises join/leave changes into a single
// round-robin event stream. Optional ignored-request counter: IOT_DROP_COUNT_EN.
module iot_event_serializer #(
    parameter int N_DEV = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    iot_event_serializer_if.slave bus
);
    localparam int              ID_W    = $clog2(N_DEV);
    localparam logic [ID_W:0]   N_DEV_W = (ID_W + 1)'(N_DEV);

    logic [N_DEV-1:0] active_map_r;
    logic [N_DEV-1:0] pend_r;
    logic [N_DEV-1:0] pdir_r;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  dev_id_r;
    logic             change_r;
    logic             on_off_r;
    logic             busy_r;

    logic [N_DEV-1:0] acc_up_s;
    logic [N_DEV-1:0] acc_dn_s;
    logic [N_DEV-1:0] acc_s;
    logic [N_DEV-1:0] grant_vec_s;
    logic [N_DEV-1:0] pend_nxt_s;
    logic [N_DEV-1:0] pdir_nxt_s;
    logic             grant_vld_s;
    logic [ID_W-1:0]  grant_idx_s;

    // Index base+off reduced modulo N_DEV; base < N_DEV and off < N_DEV.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W + 1)'(off);
        return (sum >= N_DEV_W) ? ID_W'(sum - N_DEV_W) : sum[ID_W-1:0];
    endfunction

    // A request is only a state change when it is unambiguous and not a duplicate.
    assign acc_up_s = bus.dev_up & ~bus.dev_down & ~active_map_r;
    assign acc_dn_s = bus.dev_down & ~bus.dev_up & active_map_r;
    assign acc_s    = acc_up_s | acc_dn_s;

    // Round-robin search: scan offsets from the far end so the nearest pending index wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        for (int j = N_DEV - 1; j >= 0; j--) begin
            if (pend_r[wrap_idx(ptr_r, j)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = wrap_idx(ptr_r, j);
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    assign grant_vec_s = grant_vld_s ? (N_DEV'(1) << grant_idx_s) : '0;

    // Accepted event on a pending, ungranted device cancels it; on a granted device it re-arms.
    assign pend_nxt_s = (acc_s & (grant_vec_s | ~pend_r)) | (~acc_s & pend_r & ~grant_vec_s);
    assign pdir_nxt_s = acc_up_s | (~acc_s & pdir_r);

    // Device state, pending events, pointer and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_map_r <= '0;
            pend_r       <= '0;
            pdir_r       <= '0;
            ptr_r        <= '0;
            dev_id_r     <= '0;
            change_r     <= 1'b0;
            on_off_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            active_map_r <= active_map_r ^ acc_s;
            pend_r       <= pend_nxt_s;
            pdir_r       <= pdir_nxt_s;
            busy_r       <= |pend_r;
            change_r     <= grant_vld_s;
            if (grant_vld_s) begin
                on_off_r <= pdir_r[grant_idx_s];
                dev_id_r <= grant_idx_s;
                ptr_r    <= wrap_idx(grant_idx_s, 1);
            end else begin
                on_off_r <= on_off_r;
                dev_id_r <= dev_id_r;
                ptr_r    <= ptr_r;
            end
        end
    end

    assign bus.change     = change_r;
    assign bus.on_off     = on_off_r;
    assign bus.dev_id     = dev_id_r;
    assign bus.active_map = active_map_r;
    assign bus.busy       = busy_r;

`ifdef IOT_DROP_COUNT_EN
    logic [N_DEV-1:0] ign_s;
    logic [7:0]       drop_cnt_r;

    assign ign_s = (bus.dev_up & bus.dev_down)
                 | (bus.dev_up & ~bus.dev_down & active_map_r)
                 | (bus.dev_down & ~bus.dev_up & ~active_map_r);

    // Saturating count of cycles carrying at least one ignored request.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if ((|ign_s) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
`endif

endmodule

// File: doc/iot_event_serializer.md
Name: iot_event_serializer

Overview:
- Upstream feeder for the Active IoT Devices Monitor counter.
- Takes per-device join/leave request pulses from N_DEV devices and tracks which devices are active.
- Serialises accepted state changes into at most one change/on_off pulse per clock, so the downstream counter sees a clean single-event stream.
- Round-robin arbitration among pending events; the device id accompanies each pulse.

Parameters:
N_DEV, 8, number of monitored devices (2..32)
ID_W, $clog2(N_DEV), width of dev_id output (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
dev_up  input  N_DEV  per-device join request, sampled every cycle
dev_down  input  N_DEV  per-device leave request, sampled every cycle
change  output  1  one-cycle pulse: one device changed state (drives monitor change)
on_off  output  1  direction of current event, 1=join, 0=leave (drives monitor on_off); valid only with change=1
dev_id  output  ID_W  index of device reported by the current pulse; valid only with change=1
active_map  output  N_DEV  registered per-device active state
busy  output  1  high while any event is pending

Behaviour:
- Reset, synchronous and active-high, applied at any time including mid-stream:
  - change, on_off, dev_id, active_map and busy = 0.
  - All pending bits cleared; round-robin pointer = 0.
  - Inputs are ignored while rst=1.
- Accept rule, per device i, each cycle:
  - Join accepted iff dev_up[i]=1, dev_down[i]=0 and active_map[i]=0.
  - Leave accepted iff dev_down[i]=1, dev_up[i]=0 and active_map[i]=1.
  - Both up and down high is ignored. A duplicate request (join when active, leave when inactive) is ignored.
- Accepted event, effect at the next edge:
  - active_map[i] toggles.
  - pend[i]=1 and pdir[i] = new direction.
- Cancellation: if pend[i]=1 and device i is not granted this cycle, an accepted opposite event clears pend[i]. The net effect is no pulse; active_map still toggles back.
- Grant/new-event collision: if device i is granted in the same cycle a new event for i is accepted:
  - The granted (old) event is emitted.
  - The new event becomes pend[i] with its own direction.
- Arbitration, combinational over pend:
  - Grant the first pending index at or after the pointer, wrapping modulo N_DEV.
  - On grant: pend[g] cleared, pointer = (g+1) mod N_DEV.
  - Pointer holds when nothing is pending.
- Output register, on the edge following the grant cycle:
  - change=1, on_off=pdir[g], dev_id=g.
  - Otherwise change=0; on_off and dev_id hold their last values.
- Latency: an uncontended request sampled at edge k produces change high in the cycle after edge k+1 (2 cycles).
- Throughput: one event per cycle. With M simultaneous pending events, the last one is emitted M-1 cycles after the first.
- busy = OR of pend, registered.
- No overflow is possible: each device has at most one pending event.
- Invariant: the sum of emitted joins minus leaves equals popcount(active_map) once busy=0.

Optional Feature:
- Macro: IOT_DROP_COUNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], reset to 0.
  - Increments once per cycle if any device issued an ignored request (duplicate, or up and down both high).
  - Saturates at 255; cleared only by rst.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset then dev_up=8'h01 for 1 cycle -> 2 cycles later change=1, on_off=1, dev_id=0 for exactly 1 cycle; active_map=8'h01.
- dev_up=8'hFF one cycle after reset -> 8 consecutive change pulses, dev_id 0..7 in order, all on_off=1; busy high throughout then 0; active_map=8'hFF.
- Device 3 active, dev_up[3] pulsed again -> no change pulse, active_map unchanged; with IOT_DROP_COUNT_EN, drop_cnt increments by 1.
- dev_up=8'h30 in one cycle, then dev_down[5] the next cycle while device 4 is granted -> device 5 join/leave cancel; only one pulse (dev_id=4, on_off=1); active_map=8'h10.
- dev_up and dev_down both high on device 2 -> ignored, no pulse, active_map[2]=0.
- Assert rst while 5 events are pending -> next cycle change=0, busy=0, active_map=0; after release, dev_up[7] yields dev_id=7 (pointer restarted at 0).
